// File: rtl/multdiv_pkg.sv
// Shared definitions for the mult/div issue controller: FSM encoding and
// default exception/timeout constants.
package multdiv_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_START = 2'd1;
  localparam state_t S_WAIT  = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  localparam int TIMEOUT_DEF       = 40;
  localparam int EXC_REG_DEF       = 30;
  localparam int EXC_CODE_MULT_DEF = 4;
  localparam int EXC_CODE_DIV_DEF  = 5;

endpackage

// File: rtl/multdiv_issue_if.sv
// Bundle of the execute-stage request, arithmetic-unit handshake and
// writeback signals around the mult/div issue controller.
interface multdiv_issue_if #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
);
  logic                issue_valid;
  logic                issue_is_div;
  logic [WIDTH-1:0]    issue_opA;
  logic [WIDTH-1:0]    issue_opB;
  logic [REG_BITS-1:0] issue_rd;
  logic                busy;
  logic [WIDTH-1:0]    md_operandA;
  logic [WIDTH-1:0]    md_operandB;
  logic                ctrl_MULT;
  logic                ctrl_DIV;
  logic [WIDTH-1:0]    data_result;
  logic                data_exception;
  logic                data_resultRDY;
  logic                wb_valid;
  logic [REG_BITS-1:0] wb_rd;
  logic [WIDTH-1:0]    wb_data;
  logic                wb_exc;
  logic                timeout_err;

  modport slave (
    input  issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd,
    input  data_result, data_exception, data_resultRDY,
    output busy, md_operandA, md_operandB, ctrl_MULT, ctrl_DIV,
    output wb_valid, wb_rd, wb_data, wb_exc, timeout_err
  );

  modport master (
    output issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd,
    output data_result, data_exception, data_resultRDY,
    input  busy, md_operandA, md_operandB, ctrl_MULT, ctrl_DIV,
    input  wb_valid, wb_rd, wb_data, wb_exc, timeout_err
  );
endinterface

// File: rtl/multdiv_wait_counter.sv
// Cycle counter for the WAIT state: flags the first non-zero cycle and the
// last permitted cycle (TIMEOUT-1) before forced completion.
module multdiv_wait_counter
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic count_nonzero,
  output logic count_expired
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (en && !count_expired) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign count_nonzero = |r_count;
  assign count_expired = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_issue.sv
// Issue controller for the iterative multiplier/divider: latches a request,
// pulses start, stalls until ready or timeout, then emits one writeback beat.
module multdiv_issue
  import multdiv_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int REG_BITS      = 5,
  parameter int TIMEOUT       = TIMEOUT_DEF,
  parameter int EXC_REG       = EXC_REG_DEF,
  parameter int EXC_CODE_MULT = EXC_CODE_MULT_DEF,
  parameter int EXC_CODE_DIV  = EXC_CODE_DIV_DEF
) (
  input logic            clk,
  input logic            reset,
  multdiv_issue_if.slave bus
);

  state_t              r_state;
  logic [WIDTH-1:0]    r_opA;
  logic [WIDTH-1:0]    r_opB;
  logic [REG_BITS-1:0] r_rd;
  logic                r_is_div;
  logic [REG_BITS-1:0] r_wb_rd;
  logic [WIDTH-1:0]    r_wb_data;
  logic                r_wb_exc;
  logic                r_timeout;

  logic w_nonzero;
  logic w_expired;
  logic w_rdy_acc;
  logic w_force;
  logic w_accept_issue;

  function automatic logic [WIDTH-1:0] exc_word(input logic is_div);
    return is_div ? WIDTH'(EXC_CODE_DIV) : WIDTH'(EXC_CODE_MULT);
  endfunction

  multdiv_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait_counter (
    .clk           (clk),
    .reset         (reset),
    .clr           (r_state == S_START),
    .en            (r_state == S_WAIT),
    .count_nonzero (w_nonzero),
    .count_expired (w_expired)
  );

  // The first WAIT cycle never accepts RDY: it may be left over from the previous op.
  assign w_rdy_acc      = (r_state == S_WAIT) && w_nonzero && bus.data_resultRDY;
  assign w_force        = (r_state == S_WAIT) && w_expired && !w_rdy_acc;
  assign w_accept_issue = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.issue_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_opA     <= '0;
      r_opB     <= '0;
      r_rd      <= '0;
      r_is_div  <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_wb_exc  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if (w_accept_issue) begin
        r_opA    <= bus.issue_opA;
        r_opB    <= bus.issue_opB;
        r_rd     <= bus.issue_rd;
        r_is_div <= bus.issue_is_div;
      end
      if (w_rdy_acc && !bus.data_exception) begin
        r_wb_rd   <= r_rd;
        r_wb_data <= bus.data_result;
        r_wb_exc  <= 1'b0;
      end else if (w_rdy_acc || w_force) begin
        r_wb_rd   <= REG_BITS'(EXC_REG);
        r_wb_data <= exc_word(r_is_div);
        r_wb_exc  <= 1'b1;
      end
      case (r_state)
        S_IDLE:  r_state <= w_accept_issue ? S_START : S_IDLE;
        S_START: r_state <= S_WAIT;
        S_WAIT:  r_state <= (w_rdy_acc || w_force) ? S_DONE : S_WAIT;
        S_DONE:  r_state <= w_accept_issue ? S_START : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (r_state == S_START) || (r_state == S_WAIT);
  assign bus.ctrl_MULT   = (r_state == S_START) && !r_is_div;
  assign bus.ctrl_DIV    = (r_state == S_START) && r_is_div;
  assign bus.md_operandA = r_opA;
  assign bus.md_operandB = r_opB;
  assign bus.wb_valid    = (r_state == S_DONE);
  assign bus.wb_rd       = r_wb_rd;
  assign bus.wb_data     = r_wb_data;
  assign bus.wb_exc      = r_wb_exc;
  assign bus.timeout_err = r_timeout;

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue: stub arithmetic unit, transaction-timeline
// model checked every cycle, plus literal expectations per scenario.
module tb_multdiv_issue;
  localparam int TMO = 40;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  multdiv_issue_if bus ();

  multdiv_issue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Stub unit controls
  int   stub_delay = -1;
  bit   stub_hold  = 0;
  bit   stub_force = 0;
  int   pulse_cyc  = -1;
  bit   pulse_div  = 0;

  // Observation counters
  int   n_mult, n_div, n_busy, n_wb, n_tmo;
  logic [31:0] last_rd, last_data;
  logic        last_exc;
  int   wb_hist[$];

  // Timeline model
  bit          m_active = 0;
  int          m_start = 0, m_done = -1;
  bit          m_div = 0, m_tmo = 0;
  logic [31:0] m_opA = 0, m_opB = 0;
  logic [4:0]  m_rd = 0;
  logic [4:0]  e_wb_rd = 0;
  logic [31:0] e_wb_data = 0;
  logic        e_wb_exc = 0;

  function automatic void clr_counts();
    n_mult = 0; n_div = 0; n_busy = 0; n_wb = 0; n_tmo = 0;
    wb_hist.delete();
  endfunction

  initial begin
    bit in_op, e_busy;
    int k;
    forever begin
      @(negedge clk);
      in_op  = m_active && (m_done < 0 || cyc < m_done);
      e_busy = in_op && cyc >= m_start;
      chk("busy", bus.busy, e_busy);
      chk("ctrl_MULT", bus.ctrl_MULT, m_active && cyc == m_start && !m_div);
      chk("ctrl_DIV", bus.ctrl_DIV, m_active && cyc == m_start && m_div);
      chk("wb_valid", bus.wb_valid, m_active && cyc == m_done);
      chk("timeout_err", bus.timeout_err, m_active && cyc == m_done && m_tmo);
      chk("wb_rd", bus.wb_rd, e_wb_rd);
      chk("wb_data", bus.wb_data, e_wb_data);
      chk("wb_exc", bus.wb_exc, e_wb_exc);
      chk("md_operandA", bus.md_operandA, m_opA);
      chk("md_operandB", bus.md_operandB, m_opB);

      n_mult += int'(bus.ctrl_MULT);
      n_div  += int'(bus.ctrl_DIV);
      n_busy += int'(bus.busy);
      n_tmo  += int'(bus.timeout_err);
      if (bus.ctrl_MULT || bus.ctrl_DIV) begin
        pulse_cyc = cyc;
        pulse_div = bus.ctrl_DIV;
      end
      if (bus.wb_valid) begin
        n_wb += 1;
        last_rd = 32'(bus.wb_rd); last_data = bus.wb_data; last_exc = bus.wb_exc;
        wb_hist.push_back(int'(bus.wb_data));
      end

      if (reset) begin
        m_active = 0; m_done = -1; m_tmo = 0;
        m_opA = 0; m_opB = 0; m_rd = 0; m_div = 0;
        e_wb_rd = 0; e_wb_data = 0; e_wb_exc = 0;
      end else if (m_active && m_done < 0 && cyc > m_start) begin
        k = cyc - m_start;
        if (k >= 2 && bus.data_resultRDY) begin
          m_done = cyc + 1; m_tmo = 0;
          if (bus.data_exception) begin
            e_wb_rd = 5'd30; e_wb_data = m_div ? 32'd5 : 32'd4; e_wb_exc = 1;
          end else begin
            e_wb_rd = m_rd; e_wb_data = bus.data_result; e_wb_exc = 0;
          end
        end else if (k == TMO) begin
          m_done = cyc + 1; m_tmo = 1;
          e_wb_rd = 5'd30; e_wb_data = m_div ? 32'd5 : 32'd4; e_wb_exc = 1;
        end
      end else if (!m_active || cyc == m_done) begin
        m_active = 0;
        if (bus.issue_valid) begin
          m_active = 1; m_start = cyc + 1; m_done = -1; m_tmo = 0;
          m_opA = bus.issue_opA; m_opB = bus.issue_opB;
          m_rd = bus.issue_rd; m_div = bus.issue_is_div;
        end
      end
    end
  end

  // Stub arithmetic unit
  initial begin
    logic [31:0] a, b;
    bus.data_resultRDY = 0; bus.data_result = 0; bus.data_exception = 0;
    forever begin
      @(posedge clk); #1;
      a = bus.md_operandA; b = bus.md_operandB;
      if (pulse_div) begin
        bus.data_result    = (b == 0) ? 32'd0 : a / b;
        bus.data_exception = (b == 0);
      end else begin
        bus.data_result    = a * b;
        bus.data_exception = 0;
      end
      bus.data_resultRDY = stub_force ||
        (stub_delay >= 0 && pulse_cyc >= 0 &&
         (cyc == pulse_cyc + stub_delay ||
          (stub_hold && (cyc <= pulse_cyc + 1 || cyc >= pulse_cyc + stub_delay))));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_req(input bit div, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.issue_valid = 1; bus.issue_is_div = div;
    bus.issue_opA = a; bus.issue_opB = b; bus.issue_rd = rd;
  endtask

  task automatic issue(input bit div, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    drive_req(div, a, b, rd);
    tick(1);
    bus.issue_valid = 0;
  endtask

  task automatic wait_wb(input string name);
    int i;
    for (i = 0; i < 100; i++) begin
      if (bus.wb_valid) break;
      tick(1);
    end
    if (i == 100) chk({name, "_wb_timeout"}, 0, 1);
  endtask

  initial begin
    reset = 1;
    bus.issue_valid = 0; bus.issue_is_div = 0;
    bus.issue_opA = 0; bus.issue_opB = 0; bus.issue_rd = 0;
    clr_counts();
    tick(3);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    reset = 0;
    tick(2);

    // Mult 5x7 -> rd 12 = 35
    stub_delay = 17; clr_counts();
    issue(0, 32'd5, 32'd7, 5'd12);
    wait_wb("mul1"); tick(1);
    chk("mul1_n_mult", n_mult, 1);
    chk("mul1_n_div", n_div, 0);
    chk("mul1_busy_cycles", n_busy, 18);
    chk("mul1_n_wb", n_wb, 1);
    chk("mul1_rd", last_rd, 12);
    chk("mul1_data", last_data, 35);
    chk("mul1_exc", last_exc, 0);
    tick(2);

    // Div 10/0 -> exception
    clr_counts();
    issue(1, 32'd10, 32'd0, 5'd6);
    wait_wb("div0"); tick(1);
    chk("div0_n_div", n_div, 1);
    chk("div0_n_mult", n_mult, 0);
    chk("div0_rd", last_rd, 30);
    chk("div0_data", last_data, 5);
    chk("div0_exc", last_exc, 1);
    chk("div0_tmo", n_tmo, 0);
    tick(2);

    // Stale RDY held across the next START and first WAIT cycle
    stub_hold = 1; clr_counts();
    issue(0, 32'd3, 32'd4, 5'd1);
    wait_wb("stale1"); tick(3);
    issue(0, 32'd100, 32'd3, 5'd2);
    wait_wb("stale2"); tick(1);
    stub_hold = 0;
    chk("stale_n_wb", n_wb, 2);
    chk("stale_rd", last_rd, 2);
    chk("stale_data", last_data, 300);
    chk("stale_busy_cycles", n_busy, 36);
    tick(2);

    // Unit never answers -> timeout
    stub_delay = -1; clr_counts();
    issue(0, 32'd1, 32'd1, 5'd7);
    wait_wb("tmo"); tick(1);
    chk("tmo_busy_cycles", n_busy, 41);
    chk("tmo_rd", last_rd, 30);
    chk("tmo_data", last_data, 4);
    chk("tmo_exc", last_exc, 1);
    chk("tmo_pulses", n_tmo, 1);
    tick(2);

    // Back to back with issue held in DONE
    stub_delay = 17; clr_counts();
    issue(0, -32'sd12, -32'sd5, 5'd8);
    wait_wb("b2b1");
    drive_req(0, 32'd65535, 32'd2, 5'd9);
    tick(1);
    bus.issue_valid = 0;
    chk("b2b_start_next", bus.ctrl_MULT, 1);
    wait_wb("b2b2"); tick(1);
    chk("b2b_n_wb", n_wb, 2);
    chk("b2b_first", wb_hist.size() > 0 ? wb_hist[0] : -1, 60);
    chk("b2b_second", last_data, 131070);
    chk("b2b_rd", last_rd, 9);
    tick(2);

    // Reset in the middle of WAIT, then a late RDY
    stub_delay = -1; clr_counts();
    issue(0, 32'd9, 32'd9, 5'd4);
    tick(6);
    reset = 1; tick(1); reset = 0;
    clr_counts();
    tick(3);
    stub_force = 1; tick(1); stub_force = 0;
    tick(4);
    chk("rstmid_n_wb", n_wb, 0);
    chk("rstmid_n_ctrl", n_mult + n_div, 0);
    chk("rstmid_busy", n_busy, 0);
    chk("rstmid_opA", bus.md_operandA, 0);
    stub_delay = 17; clr_counts();
    issue(0, 32'd6, 32'd7, 5'd3);
    wait_wb("after_rst"); tick(1);
    chk("after_rst_data", last_data, 42);
    chk("after_rst_rd", last_rd, 3);
    chk("after_rst_n_mult", n_mult, 1);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/multdiv_issue.md
Name: multdiv_issue

Overview:
- Upstream controller for the iterative multiplier (mult_32) and the divider.
- Accepts a mult/div request from the execute stage, latches the operands and destination register, and issues a one-cycle start pulse.
- Stalls the pipeline until the unit reports ready, then presents one writeback beat.
- Maps arithmetic exceptions to an rstatus write and guards against a hung unit with a timeout.

Parameters:
- WIDTH, 32, operand/result width.
- REG_BITS, 5, destination register index width.
- TIMEOUT, 40, maximum WAIT cycles before forced completion.
- EXC_REG, 30, register written on exception (rstatus).
- EXC_CODE_MULT, 4, rstatus value for a mult exception.
- EXC_CODE_DIV, 5, rstatus value for a div exception.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  execute stage presents a mult/div instruction.
- issue_is_div  in  1  1 = divide, 0 = multiply.
- issue_opA  in  WIDTH  multiplicand/dividend.
- issue_opB  in  WIDTH  multiplier/divisor.
- issue_rd  in  REG_BITS  destination register.
- busy  out  1  pipeline stall request.
- md_operandA  out  WIDTH  latched operand A, drives multiplicand/dividend.
- md_operandB  out  WIDTH  latched operand B, drives multiplier/divisor.
- ctrl_MULT  out  1  one-cycle multiply start pulse.
- ctrl_DIV  out  1  one-cycle divide start pulse.
- data_result  in  WIDTH  result from the selected unit.
- data_exception  in  1  exception from the selected unit.
- data_resultRDY  in  1  result-ready from the selected unit.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_rd  out  REG_BITS  writeback register.
- wb_data  out  WIDTH  writeback data.
- wb_exc  out  1  writeback is an exception/timeout.
- timeout_err  out  1  one-cycle pulse on forced completion.

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on reset.
- Reset values: every output is 0, state = IDLE, counter = 0, latches = 0.
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - busy = 0.
  - If issue_valid: latch opA, opB, rd and is_div, then go to START.
- START (exactly 1 cycle):
  - Assert ctrl_MULT (is_div = 0) or ctrl_DIV (is_div = 1); never both.
  - busy = 1. Clear the counter. Go to WAIT.
- WAIT:
  - busy = 1. The counter increments each cycle.
  - data_resultRDY is ignored while counter == 0; this masks stale RDY left over from the previous operation.
  - If counter ≥ 1 and RDY is high: capture data_result and data_exception, then go to DONE.
  - If counter == TIMEOUT-1 and RDY is not accepted: force completion with exception and pulse timeout_err. Go to DONE.
  - RDY and timeout in the same cycle: RDY wins, no timeout_err.
- DONE (1 cycle):
  - wb_valid = 1, busy = 0.
  - Normal completion: wb_rd = latched rd, wb_data = captured result, wb_exc = 0.
  - Exception or timeout: wb_rd = EXC_REG, wb_data = EXC_CODE_MULT or EXC_CODE_DIV (zero-extended), wb_exc = 1.
  - If issue_valid is high in DONE: latch the new request and go directly to START (no IDLE gap). Otherwise go to IDLE.
- Operand holding: md_operandA/B come from the latches and stay stable from START through DONE. They change only on a new latch.
- issue_valid is ignored in START and WAIT; the stall guarantees the upstream stage holds it.
- Latency: issue sampled at edge N → start pulse in cycle N+1 → RDY accepted at edge M → wb_valid in cycle M+1.
  - With mult_32, RDY arrives 17 cycles after the pulse, so wb_valid is high about 19 cycles after issue.
- wb_* outputs are registered. They hold their last value outside DONE; only wb_valid is qualified.
- Reset in any state, including mid-WAIT: return to IDLE next cycle with all outputs 0. A later RDY is ignored because the counter is 0 and the state is IDLE.
- A zero result without exception is a normal writeback (wb_rd = rd, data = 0).
- rd = 0 is not special-cased; the register file discards it.

Decomposition:
- Shared package multdiv_pkg holds:
  - the state enum (IDLE, START, WAIT, DONE);
  - the EXC_REG and EXC_CODE_* defaults;
  - the TIMEOUT default.
- One sub-module: multdiv_wait_counter.
  - Synchronous clear and enable.
  - Outputs count_nonzero and count_expired at TIMEOUT-1.

Test Plan:
- Mult 5×7, rd = 12, stub RDY 17 cycles after ctrl_MULT → exactly one ctrl_MULT pulse, ctrl_DIV = 0, busy high for 18 cycles, one wb_valid with rd = 12, data = 35, exc = 0.
- Div 10/0 with stub exception = 1 → one ctrl_DIV pulse, wb_rd = 30, wb_data = 5, wb_exc = 1, timeout_err = 0.
- RDY held high from the previous op through START and the first WAIT cycle, with the real RDY 17 cycles later → completion only on the real RDY, data = the new result.
- Stub never asserts RDY → wb_valid after TIMEOUT WAIT cycles with rd = 30, data = 4 (mult), exc = 1, one timeout_err pulse.
- Two mults back to back (-12×-5 then 65535×2) with issue_valid high in DONE → second START the cycle after DONE, writebacks 60 then 131070.
- Reset asserted mid-WAIT, then RDY pulsed 3 cycles later → busy = 0, no wb_valid, no ctrl pulses; the next issue behaves normally.
